// File: rtl/sprite_blitter_if.sv
// Pixel write bus from the sprite blitter to the framebuffer.
// A valid/ready handshake that carries one pixel's coordinates and colour.
interface sprite_blitter_if #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 24
);
  logic               valid;
  logic               ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COLOR_W-1:0] rgb;

  modport master (output valid, x, y, rgb, input ready);
  modport slave  (input valid, x, y, rgb, output ready);
endinterface

// File: rtl/sprite_blitter.sv
// Tile blitter: copies a TILE_W x TILE_H block from tile ROM to the pixel write bus.
// Supports optional flip, transparent-key skipping and output backpressure.
module sprite_blitter #(
  parameter int                  TILE_W          = 8,
  parameter int                  TILE_H          = 8,
  parameter int                  COORD_W         = 8,
  parameter int                  ADDR_W          = 12,
  parameter int                  COLOR_W         = 24,
  parameter int                  ROM_LATENCY     = 2,
  parameter logic [COLOR_W-1:0]  TRANSPARENT_KEY = COLOR_W'(24'hFF00FF)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tile_base,
  input  logic [COORD_W-1:0] x_origin,
  input  logic [COORD_W-1:0] y_origin,
  input  logic               flip_h,
  input  logic               flip_v,
  input  logic               transp_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  sprite_blitter_if.master   pix,
  output logic               busy,
  output logic               done
);

  localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [COORD_W-1:0] x0_q;
  logic [COORD_W-1:0] y0_q;
  logic               flip_h_q;
  logic               flip_v_q;
  logic               transp_q;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic [LW-1:0]      lat_cnt;

  logic [RW-1:0]      src_row;
  logic [CW-1:0]      src_col;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               last_pixel;
  logic               is_transp;

  // Tile dimensions are powers of two, so mirroring an index is a bitwise invert
  // and the row-major offset is just the concatenation of row and column.
  always_comb begin
    src_row    = flip_v_q ? ~row : row;
    src_col    = flip_h_q ? ~col : col;
    fetch_addr = base_q + ADDR_W'({src_row, src_col});
    last_pixel = (&row) && (&col);
    is_transp  = transp_q && (rom_data == TRANSPARENT_KEY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      base_q    <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      flip_h_q  <= 1'b0;
      flip_v_q  <= 1'b0;
      transp_q  <= 1'b0;
      row       <= '0;
      col       <= '0;
      lat_cnt   <= '0;
      rom_addr  <= '0;
      pix.valid <= 1'b0;
      pix.x     <= '0;
      pix.y     <= '0;
      pix.rgb   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= tile_base;
            x0_q     <= x_origin;
            y0_q     <= y_origin;
            flip_h_q <= flip_h;
            flip_v_q <= flip_v;
            transp_q <= transp_en;
            row      <= '0;
            col      <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          rom_addr <= fetch_addr;
          lat_cnt  <= LW'(ROM_LATENCY - 1);
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
          end else begin
            pix.rgb <= rom_data;
            pix.x   <= x0_q + COORD_W'(col);
            pix.y   <= y0_q + COORD_W'(row);
            // A keyed pixel is dropped here and never reaches the handshake.
            if (is_transp) begin
              col <= col + CW'(1);
              if (&col) row <= row + RW'(1);
              if (last_pixel) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              pix.valid <= 1'b1;
              state     <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (pix.ready) begin
            pix.valid <= 1'b0;
            col       <= col + CW'(1);
            if (&col) row <= row + RW'(1);
            if (last_pixel) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: scoreboarded pixel beats against a ROM model.
// Covers plain, flipped, transparent, stalled, wrapping and reset-abort tiles.
module tb_sprite_blitter;

  localparam int          ADDR_W  = 12;
  localparam int          COORD_W = 8;
  localparam int          COLOR_W = 24;
  localparam logic [23:0] KEY     = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [11:0] tile_base;
  logic [7:0]  x_origin;
  logic [7:0]  y_origin;
  logic        flip_h;
  logic        flip_v;
  logic        transp_en;
  logic [11:0] rom_addr;
  logic [23:0] rom_data;
  logic        busy;
  logic        done;

  sprite_blitter_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) pix_bus ();

  sprite_blitter dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .tile_base (tile_base),
    .x_origin  (x_origin),
    .y_origin  (y_origin),
    .flip_h    (flip_h),
    .flip_v    (flip_v),
    .transp_en (transp_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix       (pix_bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Two-cycle ROM: combinational read of the registered address plus one pipeline stage.
  logic [23:0] rom [0:4095];
  logic [23:0] rom_q;
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [7:0]  exp_x[$];
  logic [7:0]  exp_y[$];
  logic [23:0] exp_rgb[$];
  logic [11:0] exp_addr[$];
  int beats;
  int done_cnt;
  int done_cyc;
  int first_valid_cyc;
  int start_cyc;

  task automatic build_expect(input logic [11:0] base, input logic [7:0] x0, input logic [7:0] y0,
                              input logic fh, input logic fv, input logic te);
    int sr;
    int sc;
    logic [11:0] a;
    logic [23:0] d;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sr = fv ? 7 - r : r;
        sc = fh ? 7 - c : c;
        a  = 12'(int'(base) + sr * 8 + sc);
        d  = rom[a];
        if (!(te && d == KEY)) begin
          exp_x.push_back(8'(int'(x0) + c));
          exp_y.push_back(8'(int'(y0) + r));
          exp_rgb.push_back(d);
          exp_addr.push_back(a);
        end
      end
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected raster pixel.
  always @(negedge clk) begin
    if (resetn && pix_bus.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (resetn && pix_bus.valid && pix_bus.ready) begin
      if (exp_x.size() == 0) begin
        checkOutput("extra_beat", 32'(exp_x.size()), 32'd1);
      end else begin
        checkOutput("beat_x", 32'(pix_bus.x), 32'(exp_x.pop_front()));
        checkOutput("beat_y", 32'(pix_bus.y), 32'(exp_y.pop_front()));
        checkOutput("beat_rgb", 32'(pix_bus.rgb), 32'(exp_rgb.pop_front()));
        checkOutput("beat_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
      end
      beats++;
    end
    if (resetn && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic applyStimulus(input logic [11:0] base, input logic [7:0] x0, input logic [7:0] y0,
                               input logic fh, input logic fv, input logic te);
    build_expect(base, x0, y0, fh, fv, te);
    beats           = 0;
    done_cnt        = 0;
    first_valid_cyc = -1;
    @(posedge clk); #1;
    tile_base = base;
    x_origin  = x0;
    y_origin  = y0;
    flip_h    = fh;
    flip_v    = fv;
    transp_en = te;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    tile_base = 12'hABC;
    x_origin  = 8'h77;
    y_origin  = 8'h66;
    flip_h    = ~fh;
    flip_v    = ~fv;
    transp_en = ~te;
    checkOutput("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int stall_at);
    int  n;
    bit  stalled;
    stalled = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (done) break;
      if (!stalled && stall_at >= 0 && pix_bus.valid && beats == stall_at) begin
        stalled       = 1'b1;
        pix_bus.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("stall_valid", 32'(pix_bus.valid), 32'd1);
          checkOutput("stall_x", 32'(pix_bus.x), 32'(exp_x[0]));
          checkOutput("stall_y", 32'(pix_bus.y), 32'(exp_y[0]));
          checkOutput("stall_rgb", 32'(pix_bus.rgb), 32'(exp_rgb[0]));
          checkOutput("stall_addr", 32'(rom_addr), 32'(exp_addr[0]));
          @(posedge clk); #1;
        end
        pix_bus.ready = 1'b1;
      end
    end
    if (n >= 3000) checkOutput("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic finish_tile(input int exp_beats);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("beat_count", 32'(beats), 32'(exp_beats));
    checkOutput("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, 32'(pix_bus.valid), 32'd0);
    checkOutput({tag, "_x"}, 32'(pix_bus.x), 32'd0);
    checkOutput({tag, "_y"}, 32'(pix_bus.y), 32'd0);
    checkOutput({tag, "_rgb"}, 32'(pix_bus.rgb), 32'd0);
    checkOutput({tag, "_addr"}, 32'(rom_addr), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 4096; a++) rom[a] = {4'h1, 12'(a), 8'h5A};
    resetn          = 1'b0;
    start           = 1'b0;
    tile_base       = '0;
    x_origin        = '0;
    y_origin        = '0;
    flip_h          = 1'b0;
    flip_v          = 1'b0;
    transp_en       = 1'b0;
    pix_bus.ready   = 1'b1;
    beats           = 0;
    done_cnt        = 0;
    done_cyc        = 0;
    first_valid_cyc = -1;
    start_cyc       = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    $display("[TB] plain tile");
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(-1);
    finish_tile(64);
    checkOutput("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd4);
    checkOutput("t1_done_time", 32'(done_cyc - start_cyc), 32'd257);
    checkOutput("t1_last_addr", 32'(rom_addr), 32'h13F);
    checkOutput("t1_hold_x", 32'(pix_bus.x), 32'd17);
    checkOutput("t1_hold_y", 32'(pix_bus.y), 32'd27);
    checkOutput("t1_hold_rgb", 32'(pix_bus.rgb), 32'h113F5A);

    $display("[TB] flipped tile");
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b1, 1'b1, 1'b0);
    wait_done(-1);
    finish_tile(64);
    checkOutput("t2_last_addr", 32'(rom_addr), 32'h100);
    checkOutput("t2_hold_rgb", 32'(pix_bus.rgb), 32'h11005A);

    $display("[TB] transparent tile");
    rom[12'h105] = KEY;
    rom[12'h109] = KEY;
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
    wait_done(-1);
    finish_tile(62);
    checkOutput("t3_done_time", 32'(done_cyc - start_cyc), 32'd255);
    rom[12'h105] = {4'h1, 12'h105, 8'h5A};
    rom[12'h109] = {4'h1, 12'h109, 8'h5A};

    $display("[TB] backpressure on fourth pixel");
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(3);
    finish_tile(64);

    $display("[TB] screen and address wrap");
    applyStimulus(12'hFF0, 8'd252, 8'd254, 1'b0, 1'b0, 1'b0);
    wait_done(-1);
    finish_tile(64);
    checkOutput("t5_last_addr", 32'(rom_addr), 32'h02F);
    checkOutput("t5_hold_x", 32'(pix_bus.x), 32'd3);
    checkOutput("t5_hold_y", 32'(pix_bus.y), 32'd5);

    $display("[TB] start during emit, then reset mid-tile");
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    for (n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (pix_bus.valid && beats == 2) break;
    end
    checkOutput("t6_reach_emit", 32'(n < 500), 32'd1);
    tile_base = 12'h800;
    x_origin  = 8'd99;
    y_origin  = 8'd77;
    flip_h    = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (beats >= 10) break;
    end
    checkOutput("t6_reach_beat10", 32'(n < 500), 32'd1);
    checkOutput("t6_busy_mid", 32'(busy), 32'd1);
    resetn = 1'b0;
    #2;
    check_all_zero("t6_abort");
    exp_x.delete();
    exp_y.delete();
    exp_rgb.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_no_done", 32'(done_cnt), 32'd0);
    resetn = 1'b1;
    applyStimulus(12'h100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(-1);
    finish_tile(64);
    checkOutput("t6_done_time", 32'(done_cyc - start_cyc), 32'd257);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
